spi_tx_fifo: RTL and testbench

Transmit buffer directly upstream of the SPI transmitter. It accepts bytes from the APB register interface, stores them in a circular FIFO, and presents them to the transmitter's data/valid/ready handshake. The output stage qualifies the transmitter's ready so that each byte is popped exactly once per frame, even though the transmitter's ready stays high for the cycle in which it finishes a frame. It also reports level, full/empty and overflow status to the register block.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_fifo_mem.sv | 23 ++
 rtl/spi_tx_fifo.sv | 115 +++++++++++
 tb/tb_spi_tx_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and output-stage state type for the SPI transmit path.
package spi_pkg;
  localparam int SPI_DATA_W           = 8;
  localparam int SPI_TXFIFO_DEPTH_DEF = 8;
  localparam int SPI_TXFIFO_WM_DEF    = 2;

  typedef enum logic {
    READY_WAIT = 1'b0,
    ARMED      = 1'b1
  } tx_state_e;
endpackage

// File: rtl/spi_fifo_mem.sv
// TX FIFO storage: synchronous write, asynchronous read, no reset on the array.
module spi_fifo_mem
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int DEPTH   = SPI_TXFIFO_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];
endmodule

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO feeding the SPI transmitter, with one-pop-per-frame output stage.
// Optional watermark interrupt enabled by defining SPI_TX_FIFO_IRQ_EN.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W,
  parameter int DEPTH  = SPI_TXFIFO_DEPTH_DEF,
  parameter int TX_WM  = SPI_TXFIFO_WM_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_i,
  input  logic              ovf_clr_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       level_o,
  output logic              ovf_o,
  output logic              irq_o
);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) || (TX_WM > DEPTH)) begin : g_bad_cfg
    $error("spi_tx_fifo: unsupported DEPTH/TX_WM");
  end

  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_level, w_level_nxt;
  logic              r_full, r_empty, r_ready_q, r_hold, r_ovf;
  logic              w_push, w_pop, w_valid;
  logic [DATA_W-1:0] w_rdata;
  tx_state_e         w_state;

  // Transmitter ready is high for two cycles around a frame boundary; only the
  // second of them is a real load, hence the registered ready plus hold slot.
  assign w_state = (r_ready_q && !r_hold) ? ARMED : READY_WAIT;
  assign w_valid = !r_empty && en_i && (w_state == ARMED);
  assign w_pop   = w_valid && ready_i;
  assign w_push  = wr_en_i && !r_full;

  always_comb begin
    w_level_nxt = r_level;
    if (flush_i)              w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + LVL_ONE;
    else if (!w_push && w_pop) w_level_nxt = r_level - LVL_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_ready_q <= 1'b0;
      r_hold    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_level   <= w_level_nxt;
      r_full    <= (w_level_nxt == LVL_FULL);
      r_empty   <= (w_level_nxt == '0);
      r_ready_q <= ready_i;
      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_hold   <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_hold <= w_pop;
      end
      // A write-while-full beats a simultaneous clear.
      if (wr_en_i && r_full) r_ovf <= 1'b1;
      else if (ovf_clr_i)    r_ovf <= 1'b0;
    end
  end

  spi_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push && !flush_i),
    .waddr_i (r_wr_ptr),
    .wdata_i (wr_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (w_rdata)
  );

  assign data_o  = r_empty ? '0 : w_rdata;
  assign valid_o = w_valid;
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign level_o = r_level;
  assign ovf_o   = r_ovf;

`ifdef SPI_TX_FIFO_IRQ_EN
  localparam logic [AW:0] WM_LVL = (AW+1)'(TX_WM);
  logic r_irq;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= (r_level <= WM_LVL) && en_i;
  end

  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: reference queue model checked every cycle
// plus directed vector table and corner-case sequences.
module tb_spi_tx_fifo;
  localparam int DEPTH = 8;
`ifdef SPI_TX_FIFO_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  logic       clk_i = 1'b0, rst_n = 1'b1;
  logic       wr_en_i = 1'b0, flush_i = 1'b0, ovf_clr_i = 1'b0, en_i = 1'b0, ready_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic [7:0] data_o;
  logic       valid_o, full_o, empty_o, ovf_o, irq_o;
  logic [3:0] level_o;

  always #5 clk_i = ~clk_i;

  spi_tx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .TX_WM(2)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i), .ovf_clr_i(ovf_clr_i), .en_i(en_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .full_o(full_o), .empty_o(empty_o),
    .level_o(level_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of accepted bytes plus the handshake state.
  logic [7:0] q[$];
  logic [7:0] got[$];
  int         m_level = 0;
  logic       m_ready_q = 1'b0, m_hold = 1'b0, m_ovf = 1'b0, m_irq = 1'b0;
  logic       chk_on = 1'b0, last_pop = 1'b0;
  wire        e_full  = (m_level == DEPTH);
  wire        e_valid = (m_level != 0) && en_i && m_ready_q && !m_hold;
  wire        e_pop   = e_valid && ready_i;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_level <= 0; m_ready_q <= 1'b0; m_hold <= 1'b0; m_ovf <= 1'b0; m_irq <= 1'b0;
    end else begin
      if (flush_i) begin
        q.delete();
        m_level <= 0;
        m_hold  <= 1'b0;
      end else begin
        if (e_pop) void'(q.pop_front());
        if (wr_en_i && !e_full) q.push_back(wr_data_i);
        m_level <= m_level + ((wr_en_i && !e_full) ? 1 : 0) - (e_pop ? 1 : 0);
        m_hold  <= e_pop;
      end
      if (wr_en_i && e_full) m_ovf <= 1'b1;
      else if (ovf_clr_i)    m_ovf <= 1'b0;
      m_ready_q <= ready_i;
      m_irq     <= (IRQ_ON != 0) && (m_level <= 2) && en_i;
    end
  end

  always @(negedge clk_i) begin
    if (chk_on) begin
      chk("valid_o", valid_o, e_valid);
      chk("level_o", level_o, m_level);
      chk("full_o", full_o, e_full);
      chk("empty_o", empty_o, m_level == 0);
      chk("ovf_o", ovf_o, m_ovf);
      chk("irq_o", irq_o, m_irq);
      chk("data_o head", data_o, (q.size() != 0) ? int'(q[0]) : 0);
      if (valid_o && ready_i && !flush_i) begin
        chk("pop spacing", last_pop, 0);
        got.push_back(data_o);
      end
    end
    last_pop <= valid_o && ready_i && !flush_i;
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en_i = 1'b1; wr_data_i = d; tick(); wr_en_i = 1'b0;
  endtask

  task automatic chk_got(input string name, input logic [7:0] first, input int n);
    chk({name, " count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) chk(name, got[i], first + 8'(i));
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    int         lvl;
    logic       vld;
    logic [7:0] dout;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // write/pop handshake with ready held high: one pop per two cycles
    tbl[0] = '{1'b1, 8'hA5, 1, 1'b1, 8'hA5};
    tbl[1] = '{1'b0, 8'h00, 0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 8'h00, 0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 8'hB1, 1, 1'b1, 8'hB1};
    tbl[4] = '{1'b1, 8'hB2, 1, 1'b0, 8'hB2};
    tbl[5] = '{1'b0, 8'h00, 1, 1'b1, 8'hB2};
    tbl[6] = '{1'b0, 8'h00, 0, 1'b0, 8'h00};

    #2 rst_n = 1'b0;
    #1;
    chk("rst level", level_o, 0);
    chk("rst empty", empty_o, 1);
    chk("rst full", full_o, 0);
    chk("rst valid", valid_o, 0);
    chk("rst ovf", ovf_o, 0);
    chk("rst irq", irq_o, 0);
    chk("rst data", data_o, 0);
    chk_on = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    en_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wr_en_i = tbl[i].wr; wr_data_i = tbl[i].d;
      tick();
      chk($sformatf("vec%0d level", i), level_o, tbl[i].lvl);
      chk($sformatf("vec%0d valid", i), valid_o, tbl[i].vld);
      chk($sformatf("vec%0d data", i), data_o, tbl[i].dout);
    end
    wr_en_i = 1'b0;

    // fill to full with output disabled, then overflow
    ready_i = 1'b0; en_i = 1'b0; tick();
    got.delete();
    for (int i = 1; i <= 8; i++) write_byte(8'(i));
    write_byte(8'hFF);
    chk("full after 8", full_o, 1);
    chk("level after 8", level_o, 8);
    chk("ovf after write-full", ovf_o, 1);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("ovf cleared", ovf_o, 0);

    // write coinciding with a pop while full: write dropped, overflow flagged
    en_i = 1'b1; ready_i = 1'b1; tick();
    chk("armed valid", valid_o, 1);
    wr_en_i = 1'b1; wr_data_i = 8'hEE; tick();
    wr_en_i = 1'b0; ready_i = 1'b0;
    chk("full push+pop level", level_o, 7);
    chk("full push+pop ovf", ovf_o, 1);
    ready_i = 1'b1;
    repeat (20) tick();
    ready_i = 1'b0;
    chk_got("drain 01..08", 8'h01, 8);

    // transmitter frame model: 16 busy cycles, 2 ready cycles
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i));
    got.delete();
    for (int f = 0; f < 4; f++) begin
      ready_i = 1'b0; repeat (16) tick();
      ready_i = 1'b1; repeat (2) tick();
    end
    ready_i = 1'b0; tick();
    chk_got("frames", 8'h10, 4);
    chk("frames level", level_o, 0);

    // push+pop at level 3 with write pointer at 7, then wrap
    for (int i = 0; i < 3; i++) write_byte(8'h20 + 8'(i));
    got.delete();
    ready_i = 1'b1; tick();
    wr_en_i = 1'b1; wr_data_i = 8'h23; tick();
    chk("lvl3 push+pop level", level_o, 3);
    wr_data_i = 8'h24; tick();
    wr_en_i = 1'b0;
    chk("wrap push level", level_o, 4);
    repeat (12) tick();
    ready_i = 1'b0; tick();
    chk_got("wrap drain", 8'h20, 5);

    // flush at level 5 with a concurrent write
    for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
    chk("pre-flush level", level_o, 5);
    flush_i = 1'b1; wr_en_i = 1'b1; wr_data_i = 8'h77; tick();
    flush_i = 1'b0; wr_en_i = 1'b0;
    chk("flush level", level_o, 0);
    chk("flush empty", empty_o, 1);
    chk("flush valid", valid_o, 0);
    ready_i = 1'b1; repeat (4) tick(); ready_i = 1'b0;
    chk("flush write discarded", level_o, 0);

    // watermark interrupt: drain 4 -> 2, then refill to 3
    for (int i = 0; i < 4; i++) write_byte(8'h40 + 8'(i));
    tick();
    chk("irq at level 4", irq_o, 0);
    ready_i = 1'b1;
    for (int k = 0; k < 40 && level_o != 2; k++) tick();
    ready_i = 1'b0;
    chk("reach level 2", level_o, 2);
    chk("irq same cycle as level 2", irq_o, 0);
    tick();
    chk("irq cycle after level 2", irq_o, IRQ_ON);
    ready_i = 1'b1; repeat (10) tick(); ready_i = 1'b0;
    chk("irq at level 0", irq_o, IRQ_ON);
    for (int i = 0; i < 3; i++) write_byte(8'h50 + 8'(i));
    chk("level 3 refill", level_o, 3);
    chk("irq still set at refill", irq_o, IRQ_ON);
    tick();
    chk("irq falls above wm", irq_o, 0);

    // asynchronous reset mid-operation
    write_byte(8'h60);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst level", level_o, 0);
    chk("async rst empty", empty_o, 1);
    chk("async rst ovf", ovf_o, 0);
    chk("async rst data", data_o, 0);
    tick();
    rst_n = 1'b1;
    write_byte(8'hC3);
    chk("post-rst data", data_o, 8'hC3);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
